// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit owning the HI/LO registers.
// Optional early termination for multiplies is enabled by defining MULDIV_EARLY_TERM_EN.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef MULDIV_EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

  state_e             state_q;
  logic [2*WIDTH-1:0] acc_q;     // product, or {remainder, quotient}
  logic [2*WIDTH-1:0] opb_q;     // shifted multiplicand, or divisor in the low half
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q;
  logic               neg_q;
  logic               rem_neg_q;
  logic               dz_q;
  logic               done_q;
  logic               dz_pulse_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               is_mt;
  logic               is_md;
  logic               is_signed;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;
  logic [2*WIDTH-1:0] mul_sum;
  logic               mult_last;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               last_iter;

  always_comb begin
    is_mt     = (op[2:1] == 2'b10);
    is_md     = ~op[2];
    is_signed = ~op[0];
    rs_neg    = is_signed & rs_data[WIDTH-1];
    rt_neg    = is_signed & rt_data[WIDTH-1];
    rs_abs    = rs_neg ? -rs_data : rs_data;
    rt_abs    = rt_neg ? -rt_data : rt_data;
  end

  // Datapath for one iteration of either operation.
  always_comb begin
    mul_sum   = acc_q + (mplier_q[0] ? opb_q : '0);
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    mult_last = EarlyTerm ? (mplier_q[WIDTH-1:1] == '0) : last_iter;
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opb_q[WIDTH-1:0]};
    q_bit     = ~rem_diff[WIDTH];
    div_next  = {(q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], q_bit};
  end

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      opb_q      <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (op_valid && !flush) begin
            if (is_mt) begin
              if (op[0]) lo_q <= rs_data;
              else       hi_q <= rs_data;
            end else if (is_md) begin
              cnt_q     <= '0;
              is_div_q  <= op[1];
              neg_q     <= rs_neg ^ rt_neg;
              rem_neg_q <= rs_neg;
              dz_q      <= 1'b0;
              if (op[1]) begin
                opb_q    <= {{WIDTH{1'b0}}, rt_abs};
                mplier_q <= '0;
                if (rt_data == '0) begin
                  // Keep the raw dividend so HI can return it untouched.
                  acc_q   <= {{WIDTH{1'b0}}, rs_data};
                  dz_q    <= 1'b1;
                  state_q <= StFix;
                end else begin
                  acc_q   <= {{WIDTH{1'b0}}, rs_abs};
                  state_q <= StIter;
                end
              end else begin
                acc_q    <= '0;
                opb_q    <= {{WIDTH{1'b0}}, rs_abs};
                mplier_q <= rt_abs;
                state_q  <= (EarlyTerm && (rt_abs == '0)) ? StFix : StIter;
              end
            end
          end
        end
        StIter: begin
          if (flush) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (is_div_q) begin
              acc_q <= div_next;
              if (last_iter) state_q <= StFix;
            end else begin
              acc_q    <= mul_sum;
              opb_q    <= opb_q << 1;
              mplier_q <= mplier_q >> 1;
              if (mult_last) state_q <= StFix;
            end
          end
        end
        StFix: begin
          state_q <= StIdle;
          if (!flush) begin
            done_q     <= 1'b1;
            dz_pulse_q <= dz_q;
            if (dz_q) begin
              hi_q <= acc_q[WIDTH-1:0];
              lo_q <= '1;
            end else if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign div_zero = dz_pulse_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the register operands and a decoded mult/div opcode from ID/EX.
- Owns the architectural HI/LO registers.
- Asserts busy so hazard logic holds ID/EX (le low) until HI/LO are valid.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- op_valid  input  1  op/rs_data/rt_data valid this cycle
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (ignored)
- rs_data  input  WIDTH  operand A (multiplicand / dividend / MTxx source)
- rt_data  input  WIDTH  operand B (multiplier / divisor)
- flush  input  1  abort the in-flight operation (branch/exception squash)
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse; HI/LO just updated by MULT/MULTU/DIV/DIVU
- div_zero  output  1  one-cycle pulse coincident with done when the divisor was 0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0, internal datapath cleared.
- FSM states: IDLE, ITER, FIX.
- IDLE:
  - op_valid with op MTHI/MTLO: hi or lo <= rs_data at the next edge; stays IDLE; no busy, no done.
  - op_valid with op mult/div: latch operand magnitudes (two's-complement absolute value for signed ops, raw value for unsigned), result signs and op kind; counter=0.
  - Next state ITER, except DIV/DIVU with rt_data==0, which goes straight to FIX.
  - Reserved op: no effect.
- ITER (one bit per cycle, exactly WIDTH cycles, counter 0..WIDTH-1):
  - Multiply: shift-add on the 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on the remainder/quotient pair.
  - Counter==WIDTH-1 -> FIX.
- FIX, one cycle, writes hi/lo at its ending edge, then -> IDLE:
  - MULT: {hi,lo} = product, negated if the operand signs differ.
  - DIV: lo = quotient, negated if the signs differ; hi = remainder, carrying the dividend's sign.
  - Unsigned ops: no correction.
  - 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0.
  - Divide by zero: hi=rs_data, lo=all ones, div_zero=1.
- done (and div_zero) is registered and high for the one cycle after the FIX edge.
- Latency: op accepted at edge k; busy high cycles k+1 .. k+WIDTH+1 (33 cycles at WIDTH=32); hi/lo and done visible from cycle k+WIDTH+2.
- Divide by zero: busy for 1 cycle; done 2 cycles after accept.
- op_valid while busy: ignored, no queueing; upstream must stall on busy.
- flush:
  - In ITER/FIX: returns to IDLE at the next edge; hi/lo unchanged; no done.
  - In IDLE: blocks a same-cycle op_valid, including MTHI/MTLO.
  - flush and op_valid in the same cycle: flush wins.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.
- hi/lo change only at the FIX edge, on MTHI/MTLO, or on reset.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: MULT/MULTU leave ITER as soon as the remaining unshifted multiplier bits are all zero.
  - A zero multiplier goes IDLE -> FIX directly.
  - Results are unchanged.
  - Busy length = (index of highest set multiplier-magnitude bit + 1) + 1 cycles.
  - Divide timing is unaffected.
- Undefined: fixed WIDTH-iteration timing for all ops, as above.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 33 busy cycles, done; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7 -> lo=14, hi=2.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> busy 1 cycle; done and div_zero pulse together; hi=5, lo=0xFFFFFFFF.
- MTHI 0x1234 then MTLO 0x5678 (no busy) -> hi/lo updated next edge.
- MULT with flush at busy cycle 10 -> IDLE next cycle, hi/lo keep 0x1234/0x5678, no done.
- op_valid during busy -> ignored.
- rst_n low during ITER -> all outputs 0 asynchronously.
- With MULDIV_EARLY_TERM_EN: MULTU 0x12345678*3 -> busy 3 cycles; lo=0x369D0368, hi=0.
- With MULDIV_EARLY_TERM_EN: MULTU x*0 -> busy 1 cycle; hi=lo=0.
